// File: rtl/serial_out_if.sv
// Push/flow-control/line bundle for the serial_out UART transmitter.
interface serial_out_if;
   logic [7:0] data;
   logic       ie;
   logic       cts_n;
   logic       tx;
   logic       busy;
   logic       full;
   logic       empty;
   logic       overflow;

   modport master (
      output data, ie, cts_n,
      input  tx, busy, full, empty, overflow
   );

   modport slave (
      input  data, ie, cts_n,
      output tx, busy, full, empty, overflow
   );
endinterface

// File: rtl/serial_out.sv
// UART 8N1 transmitter fed from a byte FIFO, with frame starts gated by remote clear-to-send.
module serial_out #(
   parameter int unsigned CLK_FREQUENCY_HZ = 108_000_000,
   parameter int unsigned SERIAL_BPS       = 1_000_000,
   parameter int unsigned FIFO_DEPTH_LOG2  = 4
) (
   input logic         clk,
   input logic         reset,
   serial_out_if.slave bus
);
   localparam int unsigned BIT_CYCLES = CLK_FREQUENCY_HZ / SERIAL_BPS;
   localparam int unsigned BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int unsigned DEPTH      = 1 << FIFO_DEPTH_LOG2;
   localparam int unsigned CNT_W      = FIFO_DEPTH_LOG2 + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  COUNT_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   logic [7:0]                 mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]           count_q, count_d;
   logic                       full_q, empty_q, overflow_q;
   logic                       push, pop, can_start, baud_end;

   state_e                     state_q, state_d;
   logic [BAUD_W-1:0]          baud_q, baud_d;
   logic [2:0]                 bit_q, bit_d;
   logic [7:0]                 shift_q, shift_d;
   logic                       tx_q, tx_d, busy_q, busy_d;
   logic                       cts_q;

   // A push into a full FIFO is rejected even when a pop frees a slot this cycle.
   assign push      = bus.ie && (count_q != COUNT_FULL);
   assign can_start = (count_q != '0) && !cts_q;
   assign baud_end  = (baud_q == BAUD_LAST);

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= bus.data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         overflow_q <= 1'b0;
         cts_q      <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         full_q     <= (count_q == COUNT_FULL);
         empty_q    <= (count_q == '0);
         overflow_q <= bus.ie && (count_q == COUNT_FULL);
         // cts_n comes from the remote side; register it before it steers a frame start.
         cts_q      <= bus.cts_n;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (can_start) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               baud_d  = '0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StData: begin
            if (baud_end) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = StStop;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         StStop: begin
            if (baud_end) begin
               baud_d = '0;
               if (can_start) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // tx and busy follow the next state so the line changes on the same edge as the state.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != StIdle);
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.busy     = busy_q;
   assign bus.full     = full_q;
   assign bus.empty    = empty_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_out.sv
// Directed bench for serial_out: cycle-exact vector table plus a UART receiver model on tx.
module tb_serial_out;
   localparam int BIT  = 108;
   localparam int HALF = 54;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   ovf_seen = 0;

   logic [8:0] rx_q[$];
   int         rx_t[$];

   serial_out_if bus ();

   serial_out dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.overflow === 1'b1) ovf_seen++;

   // Receiver model: stop bit kept in bit 8 so framing errors show up in comparisons.
   initial begin
      int         st;
      logic [7:0] b;
      logic       sb;
      forever begin
         @(negedge clk);
         if (bus.tx === 1'b0) begin
            st = cyc;
            repeat (HALF) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (BIT) @(negedge clk);
               b[k] = bus.tx;
            end
            repeat (BIT) @(negedge clk);
            sb = bus.tx;
            rx_q.push_back({sb, b});
            rx_t.push_back(st);
         end
      end
   end

   typedef struct {
      int   off;
      logic tx;
      logic busy;
      logic empty;
   } vec_t;

   vec_t vec[17];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input logic [7:0] b);
      bus.data = b;
      bus.ie   = 1'b1;
      tick();
      bus.ie   = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget);
      int k = 0;
      while (rx_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check("rx frame count", rx_q.size(), n);
   endtask

   task automatic check_rx(input int i, input logic [7:0] b);
      if (i < rx_q.size()) check("rx byte", {23'd0, rx_q[i]}, {23'd0, 1'b1, b});
      else                 check("rx byte missing", 32'hffff_ffff, {23'd0, 1'b1, b});
   endtask

   task automatic flush_rx();
      rx_q.delete();
      rx_t.delete();
   endtask

   initial begin
      int t0, c, ovf0, bad;

      bus.data  = 8'h00;
      bus.ie    = 1'b0;
      bus.cts_n = 1'b0;
      reset     = 1'b1;
      repeat (3) tick();
      check("reset tx", bus.tx, 1'b1);
      check("reset busy", bus.busy, 1'b0);
      check("reset full", bus.full, 1'b0);
      check("reset empty", bus.empty, 1'b1);
      check("reset overflow", bus.overflow, 1'b0);
      reset = 1'b0;
      repeat (5) tick();

      // Single byte 0x55: offsets relative to the push cycle.
      vec[0]  = '{1,    1'b1, 1'b0, 1'b1};
      vec[1]  = '{2,    1'b0, 1'b1, 1'b0};
      vec[2]  = '{3,    1'b0, 1'b1, 1'b1};
      vec[3]  = '{109,  1'b0, 1'b1, 1'b1};
      vec[4]  = '{110,  1'b1, 1'b1, 1'b1};
      vec[5]  = '{217,  1'b1, 1'b1, 1'b1};
      vec[6]  = '{218,  1'b0, 1'b1, 1'b1};
      vec[7]  = '{326,  1'b1, 1'b1, 1'b1};
      vec[8]  = '{434,  1'b0, 1'b1, 1'b1};
      vec[9]  = '{542,  1'b1, 1'b1, 1'b1};
      vec[10] = '{650,  1'b0, 1'b1, 1'b1};
      vec[11] = '{758,  1'b1, 1'b1, 1'b1};
      vec[12] = '{866,  1'b0, 1'b1, 1'b1};
      vec[13] = '{973,  1'b0, 1'b1, 1'b1};
      vec[14] = '{974,  1'b1, 1'b1, 1'b1};
      vec[15] = '{1081, 1'b1, 1'b1, 1'b1};
      vec[16] = '{1082, 1'b1, 1'b0, 1'b1};

      t0 = cyc;
      push(8'h55);
      for (int i = 0; i < 17; i++) begin
         wait_until(t0 + vec[i].off);
         check($sformatf("single tx @%0d", vec[i].off), bus.tx, vec[i].tx);
         check($sformatf("single busy @%0d", vec[i].off), bus.busy, vec[i].busy);
         check($sformatf("single empty @%0d", vec[i].off), bus.empty, vec[i].empty);
      end
      wait_rx(1, 200);
      check_rx(0, 8'h55);
      flush_rx();
      repeat (100) tick();

      // Back-to-back frames with no idle gap.
      t0 = cyc;
      push(8'h41);
      push(8'h42);
      push(8'h43);
      wait_until(t0 + 3241);
      check("b2b busy last stop", bus.busy, 1'b1);
      tick();
      check("b2b busy end", bus.busy, 1'b0);
      wait_rx(3, 300);
      check_rx(0, 8'h41);
      check_rx(1, 8'h42);
      check_rx(2, 8'h43);
      for (int i = 0; i < 3; i++) begin
         if (i < rx_t.size()) check("b2b start", rx_t[i], t0 + 2 + 1080 * i);
         else                 check("b2b start missing", 32'hffff_ffff, t0 + 2 + 1080 * i);
      end
      flush_rx();
      repeat (100) tick();

      // Overflow with cts_n held high.
      bus.cts_n = 1'b1;
      repeat (4) tick();
      ovf0 = ovf_seen;
      t0 = cyc;
      for (int i = 0; i <= 16; i++) begin
         if (i == 16) check("ovf before 17th", bus.overflow, 1'b0);
         push(8'(i));
      end
      check("ovf full", bus.full, 1'b1);
      check("ovf pulse", bus.overflow, 1'b1);
      tick();
      check("ovf pulse end", bus.overflow, 1'b0);
      repeat (200) tick();
      check("ovf tx idle", bus.tx, 1'b1);
      check("ovf busy idle", bus.busy, 1'b0);
      check("ovf single pulse", ovf_seen - ovf0, 1);
      c = cyc;
      bus.cts_n = 1'b0;
      tick();
      check("ovf tx before start", bus.tx, 1'b1);
      tick();
      check("ovf full until pop", bus.full, 1'b1);
      check("ovf tx start", bus.tx, 1'b0);
      tick();
      check("ovf full cleared", bus.full, 1'b0);
      wait_rx(16, 16 * 1080 + 500);
      for (int i = 0; i < 16; i++) check_rx(i, 8'(i));
      flush_rx();
      repeat (100) tick();

      // Flow control mid-frame.
      t0 = cyc;
      push(8'hA5);
      push(8'h5A);
      wait_until(t0 + 502);
      bus.cts_n = 1'b1;
      wait_until(t0 + 1081);
      check("flow last stop busy", bus.busy, 1'b1);
      tick();
      check("flow idle busy", bus.busy, 1'b0);
      check("flow idle tx", bus.tx, 1'b1);
      wait_until(t0 + 1500);
      check("flow held tx", bus.tx, 1'b1);
      check("flow held empty", bus.empty, 1'b0);
      bus.cts_n = 1'b0;
      tick();
      check("flow tx +1", bus.tx, 1'b1);
      tick();
      check("flow tx +2", bus.tx, 1'b0);
      wait_rx(2, 1300);
      check_rx(0, 8'hA5);
      check_rx(1, 8'h5A);
      flush_rx();
      repeat (100) tick();

      // Reset mid-frame discards queued bytes.
      t0 = cyc;
      for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
      wait_until(t0 + 302);
      check("rst busy before", bus.busy, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst tx", bus.tx, 1'b1);
      check("rst empty", bus.empty, 1'b1);
      check("rst busy", bus.busy, 1'b0);
      bad = 0;
      for (int i = 0; i < 2500; i++) begin
         tick();
         if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
      end
      check("rst no frames", bad, 0);
      flush_rx();

      // Wrap-around: 40 bytes in bursts of 10 through the 16-deep FIFO.
      ovf0 = ovf_seen;
      t0 = cyc;
      for (int b = 0; b < 4; b++) begin
         wait_until(t0 + b * 10800);
         for (int i = 0; i < 10; i++) push(8'h80 + 8'(b * 10 + i));
      end
      wait_rx(40, 12000);
      for (int i = 0; i < 40; i++) check_rx(i, 8'h80 + 8'(i));
      check("wrap no overflow", ovf_seen - ovf0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
